jimmy_fetch_unit: RTL and testbench
===================================

Name: jimmy_fetch_unit

Overview:
- Instruction fetch sequencer for the Jimmy 8-bit CPU. Drives the program memory address bus and reads its combinational data bus.
- Assembles one- and two-byte instructions and hands each complete instruction to the decoder over a valid/ready handshake.
- Owns the program counter, including branch redirects and halt.

Parameters:
- RESET_PC, 8'h00, program counter value after reset.
- CNT_W, 16, width of the saturating accepted-instruction counter.

Ports:
- program_clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- address_bus  output  8  program memory address; always equals the internal PC.
- data_bus  input  8  program memory read data, combinational from address_bus.
- halt  input  1  freezes fetching while high.
- redirect  input  1  one-cycle branch/jump request.
- redirect_addr  input  8  new PC, sampled when redirect=1.
- instr_valid  output  1  a complete instruction is presented.
- instr_ready  input  1  decoder accepts the instruction when high with instr_valid.
- instr_opcode  output  8  first instruction byte.
- instr_imm  output  8  second byte; 8'h00 for one-byte instructions.
- instr_two_byte  output  1  presented instruction is two bytes.
- instr_pc  output  8  address of the presented opcode byte.
- instr_count  output  CNT_W  number of accepted instructions, saturating.

Behaviour:
- Reset (synchronous, active-high) sets: PC=RESET_PC, state=FETCH_OP, instr_valid=0, instr_opcode/instr_imm/instr_pc=0, instr_two_byte=0, instr_count=0. Reset overrides every other input.
- The two-byte rule applies to the opcode byte b: two-byte iff b[7:6]==2'b10 and b[5:4] is 2'b00 or 2'b10.
  - Two-byte examples: LD_IMM, CMP_IMM, BRA, BHI, BEQ.
  - Every other byte is one-byte, including DEC, INPUT, OUTPUT, ADD, MUL, MOV, NOP and b[7:6]==2'b11.
- Priority is reset > redirect > halt > normal.
- FSM states: FETCH_OP, FETCH_IMM, PRESENT.
- FETCH_OP:
  - On the edge: opcode_reg<=data_bus, instr_pc<=PC, PC<=PC+1.
  - Next state is FETCH_IMM if the byte is two-byte; otherwise PRESENT, with imm=0 and two_byte=0.
- FETCH_IMM:
  - On the edge: imm_reg<=data_bus, PC<=PC+1, two_byte=1, next state PRESENT.
- PRESENT:
  - instr_valid=1. Outputs are stable until accepted.
  - On instr_ready=1: instr_count increments, saturating at all-ones, then FETCH_OP.
  - Otherwise stay in PRESENT.
  - Output latency: a one-byte instruction is valid 1 cycle after entering FETCH_OP; a two-byte instruction after 2 cycles.
  - Maximum throughput is one instruction per 2 cycles for one-byte and per 3 cycles for two-byte.
- instr_valid is registered: high exactly in PRESENT, low in all other states.
- Halt:
  - In FETCH_OP or FETCH_IMM: no capture, PC held, state held.
  - In PRESENT: the handshake still completes on instr_ready; the FSM then waits in FETCH_OP.
- Redirect (any state):
  - PC<=redirect_addr, state<=FETCH_OP, and any partially fetched opcode is discarded.
  - A PRESENT instruction not accepted in the same cycle is dropped; instr_valid is 0 on the next cycle.
  - If instr_ready and redirect coincide in PRESENT, the instruction counts as accepted (instr_count increments) and the PC still takes redirect_addr.
- PC arithmetic is 8-bit modulo.
  - 8'hFF+1 wraps to 8'h00.
  - A two-byte opcode at 8'hFF takes its immediate from address 8'h00.
- address_bus = PC at all times. The memory is combinational, so data_bus is sampled on the same edge.

Test Plan:
- Reset then fetch: rom[0]=8'h98 (INPUT R0), rom[1]=8'h8C, rom[2]=8'h01, instr_ready=1.
  - Expect instr_valid at cycle 2 with opcode 8'h98, imm 0, pc 0, two_byte 0.
  - Then opcode 8'h8C, imm 8'h01, pc 1, two_byte 1.
  - Then address_bus=3 and instr_count=2.
- Backpressure: hold instr_ready=0 for 5 cycles while presenting 8'hA8/8'h00 (BRA 0).
  - Outputs stay constant, address_bus stays 2, instr_count does not change.
  - Release ready -> instr_count increments once.
- Redirect mid-fetch: pulse redirect with redirect_addr=8'h0D while in FETCH_IMM.
  - Next cycle: address_bus=8'h0D, instr_valid=0, no instruction presented for the discarded opcode.
- Simultaneous accept and redirect in PRESENT, redirect_addr=8'h06.
  - instr_count increments and the next instr_pc is 8'h06.
- Halt and wrap: RESET_PC=8'hFF, rom[255]=8'h80 (LD_IMM), rom[0]=8'h05, halt=1 for 3 cycles then 0.
  - address_bus stays 8'hFF while halted.
  - Then presents opcode 8'h80, imm 8'h05, pc 8'hFF, and address_bus becomes 8'h01.
- Reset mid-PRESENT: assert reset while instr_valid=1.
  - Next cycle: instr_valid=0, address_bus=RESET_PC, instr_count=0.

Source files
------------

// File: rtl/jimmy_fetch_unit.sv
// Instruction fetch sequencer for the Jimmy 8-bit CPU.
// Walks the program counter over a combinational program memory and assembles
// one- and two-byte instructions. Each complete instruction is handed to the
// decoder over a valid/ready handshake. Branch redirects and halt are handled
// here as well.
//
// Ports:
//   program_clk    - system clock, rising edge
//   reset          - synchronous, active-high reset
//   address_bus    - program memory address (always the PC)
//   data_bus       - program memory read data, combinational from address_bus
//   halt           - freezes fetching while high
//   redirect       - one-cycle branch/jump request
//   redirect_addr  - new PC, sampled with redirect
//   instr_valid    - a complete instruction is presented
//   instr_ready    - decoder accepts the presented instruction
//   instr_opcode   - first instruction byte
//   instr_imm      - second byte, 8'h00 for one-byte instructions
//   instr_two_byte - presented instruction is two bytes long
//   instr_pc       - address of the presented opcode byte
//   instr_count    - saturating count of accepted instructions
module jimmy_fetch_unit #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             program_clk,
  input  logic             reset,
  output logic [7:0]       address_bus,
  input  logic [7:0]       data_bus,
  input  logic             halt,
  input  logic             redirect,
  input  logic [7:0]       redirect_addr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [7:0]       instr_opcode,
  output logic [7:0]       instr_imm,
  output logic             instr_two_byte,
  output logic [7:0]       instr_pc,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {StFetchOp, StFetchImm, StPresent} state_e;

  state_e           state_q;
  logic [7:0]       pc_q;
  logic [7:0]       opcode_q;
  logic [7:0]       imm_q;
  logic [7:0]       instr_pc_q;
  logic             two_byte_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;

  logic             op_is_two_byte;
  logic             accept;
  logic [CNT_W-1:0] count_inc;

  always_comb begin
    // Two-byte opcodes: b[7:6]==2'b10 with b[5:4] in {00,10}, i.e. bit 4 clear.
    op_is_two_byte = (data_bus[7:6] == 2'b10) && !data_bus[4];
    accept         = (state_q == StPresent) && instr_ready;
    count_inc      = (&count_q) ? count_q : count_q + CNT_W'(1);
  end

  always_ff @(posedge program_clk) begin
    if (reset) begin
      state_q    <= StFetchOp;
      pc_q       <= RESET_PC;
      opcode_q   <= 8'h00;
      imm_q      <= 8'h00;
      instr_pc_q <= 8'h00;
      two_byte_q <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else if (redirect) begin
      // An instruction accepted in the same cycle still counts; anything
      // partially fetched or presented-but-unaccepted is dropped.
      state_q <= StFetchOp;
      pc_q    <= redirect_addr;
      valid_q <= 1'b0;
      if (accept) begin
        count_q <= count_inc;
      end
    end else begin
      unique case (state_q)
        StFetchOp: begin
          if (!halt) begin
            opcode_q   <= data_bus;
            instr_pc_q <= pc_q;
            pc_q       <= pc_q + 8'd1;
            if (op_is_two_byte) begin
              state_q <= StFetchImm;
            end else begin
              imm_q      <= 8'h00;
              two_byte_q <= 1'b0;
              valid_q    <= 1'b1;
              state_q    <= StPresent;
            end
          end
        end
        StFetchImm: begin
          if (!halt) begin
            imm_q      <= data_bus;
            pc_q       <= pc_q + 8'd1;
            two_byte_q <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= StPresent;
          end
        end
        StPresent: begin
          // Halt does not block the handshake; it takes effect in StFetchOp.
          if (instr_ready) begin
            count_q <= count_inc;
            valid_q <= 1'b0;
            state_q <= StFetchOp;
          end
        end
        default: begin
          state_q <= StFetchOp;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign address_bus    = pc_q;
  assign instr_valid    = valid_q;
  assign instr_opcode   = opcode_q;
  assign instr_imm      = imm_q;
  assign instr_two_byte = two_byte_q;
  assign instr_pc       = instr_pc_q;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_jimmy_fetch_unit.sv
module tb_jimmy_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_addr = 8'h00;
  logic        ready = 1'b0;
  logic [7:0]  rom [256];

  // Main instance: RESET_PC 0, 16-bit counter.
  logic [7:0]  addr, data, op, imm, ipc;
  logic        valid, two;
  logic [15:0] count;

  // Second instance: RESET_PC 8'hFF, 2-bit counter for wrap and saturation.
  logic [7:0]  addr2, data2, op2, imm2, ipc2;
  logic        valid2, two2;
  logic [1:0]  count2;

  int nvec = 0;
  int nfail = 0;

  assign data  = rom[addr];
  assign data2 = rom[addr2];

  jimmy_fetch_unit #(.RESET_PC(8'h00), .CNT_W(16)) dut (
    .program_clk(clk), .reset(reset), .address_bus(addr), .data_bus(data),
    .halt(halt), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(valid), .instr_ready(ready), .instr_opcode(op), .instr_imm(imm),
    .instr_two_byte(two), .instr_pc(ipc), .instr_count(count)
  );

  jimmy_fetch_unit #(.RESET_PC(8'hFF), .CNT_W(2)) dut2 (
    .program_clk(clk), .reset(reset), .address_bus(addr2), .data_bus(data2),
    .halt(halt), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(valid2), .instr_ready(ready), .instr_opcode(op2), .instr_imm(imm2),
    .instr_two_byte(two2), .instr_pc(ipc2), .instr_count(count2)
  );

  always #5 clk = ~clk;

  function automatic logic is_two(input logic [7:0] b);
    return (b[7:6] == 2'b10) && ((b[5:4] == 2'b00) || (b[5:4] == 2'b10));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom(8'h00);
    halt = 1'b0; redirect = 1'b0; ready = 1'b0;
    do_reset();
    nvec++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", valid); end
    nvec++; if (addr !== 8'h00) begin nfail++; $display("FAIL reset_addr got %h want 00", addr); end
    nvec++; if (addr2 !== 8'hFF) begin nfail++; $display("FAIL reset_addr2 got %h want ff", addr2); end
    nvec++; if (count !== 16'd0) begin nfail++; $display("FAIL reset_count got %0d want 0", count); end
    nvec++; if (op !== 8'h00 || imm !== 8'h00 || ipc !== 8'h00 || two !== 1'b0) begin
      nfail++; $display("FAIL reset_fields got op=%h imm=%h pc=%h two=%b want zeros", op, imm, ipc, two);
    end
  endtask

  task automatic test_fetch();
    fill_rom(8'h00);
    rom[0] = 8'h98; rom[1] = 8'h8C; rom[2] = 8'h01;
    ready = 1'b1;
    do_reset();
    step();
    nvec++; if (valid !== 1'b1) begin nfail++; $display("FAIL fetch1_valid got %b want 1", valid); end
    nvec++; if (op !== 8'h98 || imm !== 8'h00 || ipc !== 8'h00 || two !== 1'b0) begin
      nfail++; $display("FAIL fetch1_fields got op=%h imm=%h pc=%h two=%b want 98 00 00 0", op, imm, ipc, two);
    end
    step(); step(); step();
    nvec++; if (valid !== 1'b1) begin nfail++; $display("FAIL fetch2_valid got %b want 1", valid); end
    nvec++; if (op !== 8'h8C || imm !== 8'h01 || ipc !== 8'h01 || two !== 1'b1) begin
      nfail++; $display("FAIL fetch2_fields got op=%h imm=%h pc=%h two=%b want 8c 01 01 1", op, imm, ipc, two);
    end
    step();
    nvec++; if (addr !== 8'h03) begin nfail++; $display("FAIL fetch_addr got %h want 03", addr); end
    nvec++; if (count !== 16'd2) begin nfail++; $display("FAIL fetch_count got %0d want 2", count); end
    nvec++; if (valid !== 1'b0) begin nfail++; $display("FAIL fetch_valid_drop got %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    fill_rom(8'h00);
    rom[0] = 8'hA8;
    ready = 1'b0;
    do_reset();
    step(); step();
    for (int i = 0; i < 5; i++) begin
      nvec++; if (valid !== 1'b1 || op !== 8'hA8 || imm !== 8'h00 || ipc !== 8'h00 || two !== 1'b1) begin
        nfail++; $display("FAIL bp_hold[%0d] got v=%b op=%h imm=%h pc=%h two=%b want 1 a8 00 00 1",
                          i, valid, op, imm, ipc, two);
      end
      nvec++; if (addr !== 8'h02 || count !== 16'd0) begin
        nfail++; $display("FAIL bp_addr_count[%0d] got addr=%h cnt=%0d want 02 0", i, addr, count);
      end
      step();
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    nvec++; if (count !== 16'd1) begin nfail++; $display("FAIL bp_release_count got %0d want 1", count); end
    step(); step();
    nvec++; if (count !== 16'd1) begin nfail++; $display("FAIL bp_single_inc got %0d want 1", count); end
  endtask

  task automatic test_redirect_mid();
    fill_rom(8'h00);
    rom[0] = 8'h8C; rom[8'h0D] = 8'h42;
    ready = 1'b1;
    do_reset();
    step();
    redirect = 1'b1; redirect_addr = 8'h0D;
    step();
    redirect = 1'b0;
    nvec++; if (addr !== 8'h0D) begin nfail++; $display("FAIL redir_addr got %h want 0d", addr); end
    nvec++; if (valid !== 1'b0) begin nfail++; $display("FAIL redir_valid got %b want 0", valid); end
    step();
    nvec++; if (valid !== 1'b1 || op !== 8'h42 || ipc !== 8'h0D || two !== 1'b0) begin
      nfail++; $display("FAIL redir_next got v=%b op=%h pc=%h two=%b want 1 42 0d 0", valid, op, ipc, two);
    end
  endtask

  task automatic test_accept_redirect();
    fill_rom(8'h00);
    rom[0] = 8'h98; rom[6] = 8'h10;
    ready = 1'b1;
    do_reset();
    step();
    nvec++; if (valid !== 1'b1) begin nfail++; $display("FAIL accredir_pre got %b want 1", valid); end
    redirect = 1'b1; redirect_addr = 8'h06;
    step();
    redirect = 1'b0;
    nvec++; if (count !== 16'd1) begin nfail++; $display("FAIL accredir_count got %0d want 1", count); end
    nvec++; if (valid !== 1'b0 || addr !== 8'h06) begin
      nfail++; $display("FAIL accredir_state got v=%b addr=%h want 0 06", valid, addr);
    end
    step();
    nvec++; if (valid !== 1'b1 || ipc !== 8'h06 || op !== 8'h10) begin
      nfail++; $display("FAIL accredir_next got v=%b pc=%h op=%h want 1 06 10", valid, ipc, op);
    end
  endtask

  task automatic test_halt_wrap();
    fill_rom(8'h00);
    rom[255] = 8'h80; rom[0] = 8'h05;
    ready = 1'b0; halt = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (addr2 !== 8'hFF || valid2 !== 1'b0) begin
        nfail++; $display("FAIL halt_hold[%0d] got addr=%h v=%b want ff 0", i, addr2, valid2);
      end
    end
    halt = 1'b0;
    step(); step();
    nvec++; if (valid2 !== 1'b1 || op2 !== 8'h80 || imm2 !== 8'h05 || ipc2 !== 8'hFF || two2 !== 1'b1) begin
      nfail++; $display("FAIL wrap_fields got v=%b op=%h imm=%h pc=%h two=%b want 1 80 05 ff 1",
                        valid2, op2, imm2, ipc2, two2);
    end
    nvec++; if (addr2 !== 8'h01) begin nfail++; $display("FAIL wrap_addr got %h want 01", addr2); end
  endtask

  task automatic test_saturate();
    fill_rom(8'h00);
    ready = 1'b1;
    do_reset();
    repeat (12) step();
    nvec++; if (count !== 16'd6) begin nfail++; $display("FAIL thru_count got %0d want 6", count); end
    nvec++; if (count2 !== 2'd3) begin nfail++; $display("FAIL sat_count got %0d want 3", count2); end
    repeat (4) step();
    nvec++; if (count2 !== 2'd3) begin nfail++; $display("FAIL sat_hold got %0d want 3", count2); end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_present();
    fill_rom(8'h98);
    ready = 1'b1;
    do_reset();
    step(); step();
    ready = 1'b0;
    step();
    nvec++; if (valid !== 1'b1 || count !== 16'd1) begin
      nfail++; $display("FAIL rstmid_pre got v=%b cnt=%0d want 1 1", valid, count);
    end
    ready = 1'b1;
    do_reset();
    nvec++; if (valid !== 1'b0 || addr !== 8'h00 || count !== 16'd0) begin
      nfail++; $display("FAIL rstmid_post got v=%b addr=%h cnt=%0d want 0 00 0", valid, addr, count);
    end
    ready = 1'b0;
  endtask

  // Transaction-level model: the accepted stream is the sequence of
  // instructions laid out in memory from the current start address; a redirect
  // restarts the stream at the new address.
  task automatic test_random();
    logic [7:0] exp_pc, e_op, e_imm, nxt, len;
    logic       e_two, r_ready;
    int         acc;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    halt = 1'b0; redirect = 1'b0; ready = 1'b0;
    do_reset();
    exp_pc = 8'h00; acc = 0; len = 8'd1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (valid === 1'b1) begin
        e_op  = rom[exp_pc];
        e_two = is_two(e_op);
        nxt   = exp_pc + 8'd1;
        e_imm = e_two ? rom[nxt] : 8'h00;
        len   = e_two ? 8'd2 : 8'd1;
        nvec++; if (op !== e_op || imm !== e_imm || two !== e_two || ipc !== exp_pc) begin
          nfail++; $display("FAIL rnd_instr@%0d got op=%h imm=%h two=%b pc=%h want %h %h %b %h",
                            cyc, op, imm, two, ipc, e_op, e_imm, e_two, exp_pc);
        end
        nvec++; if (addr !== exp_pc + len) begin
          nfail++; $display("FAIL rnd_addr@%0d got %h want %h", cyc, addr, exp_pc + len);
        end
      end
      nvec++; if (count !== 16'(acc)) begin
        nfail++; $display("FAIL rnd_count@%0d got %0d want %0d", cyc, count, acc);
      end
      r_ready       = 1'($urandom_range(0, 1));
      halt          = ($urandom_range(0, 3) == 0);
      redirect      = ($urandom_range(0, 15) == 0);
      redirect_addr = 8'($urandom);
      if (valid === 1'b1 && r_ready) begin
        acc++;
        exp_pc = exp_pc + len;
      end
      if (redirect) exp_pc = redirect_addr;
      ready = r_ready;
      step();
    end
    halt = 1'b0; redirect = 1'b0; ready = 1'b0;
    nvec++; if (acc < 10) begin nfail++; $display("FAIL rnd_progress got %0d accepted want >= 10", acc); end
  endtask

  initial begin
    fill_rom(8'h00);
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_mid();
    test_accept_redirect();
    test_halt_wrap();
    test_saturate();
    test_reset_mid_present();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
